jk_bank_arbiter: RTL

Arbiter and sequencer for a WIDTH-bit bank of gate-level master-slave JK flip-flops (each bit: j, k, clk, active-low clear `cl`, q). Two requesters, e.g. the decode and writeback stages of the MIPS pipeline, issue bank operations. The block grants one requester at a time round-robin, drives the bank's J/K vectors and clear for exactly one cycle, waits for the slave latches to settle, then returns the bank contents with a done pulse. J and K are forced to 0 (hold) at all other times.

---
 rtl/jk_bank_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter/sequencer for a master-slave JK flip-flop bank: one op per grant,
// drive one cycle, settle, respond. Optional wrap detect: define JK_BANK_ARB_WRAP_CHK_EN.
module jk_bank_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             cl,
    input  logic             req0,
    input  logic             req1,
    input  logic [2:0]       op0,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] rdata,
    output logic             ovf,
    output logic [WIDTH-1:0] bank_j,
    output logic [WIDTH-1:0] bank_k,
    output logic             bank_cl,
    input  logic [WIDTH-1:0] bank_q
);

    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, RESP} state_t;
    typedef enum logic [2:0] {
        OP_HOLD, OP_LOAD, OP_SET, OP_CLR, OP_TOGGLE, OP_INC, OP_DEC, OP_CLRALL
    } op_t;

    state_t           state;
    logic             owner;
    logic             last_gnt;
    logic             win;
    op_t              sel_op;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] inc_t;
    logic [WIDTH-1:0] dec_t;
    logic [WIDTH-1:0] next_j;
    logic [WIDTH-1:0] next_k;

    // Port 1 wins only when it asks alone, or both ask and port 0 went last.
    assign win      = req1 && (!req0 || !last_gnt);
    assign sel_op   = op_t'(win ? op1 : op0);
    assign sel_data = win ? data1 : data0;

    // Counter toggle masks: bit i flips when every lower bit is 1 (INC) or 0 (DEC).
    always_comb begin
        inc_t[0] = 1'b1;
        dec_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            inc_t[i] = inc_t[i-1] & bank_q[i-1];
            dec_t[i] = dec_t[i-1] & ~bank_q[i-1];
        end
    end

    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        next_j = '0;
        next_k = '0;
        case (sel_op)
            OP_LOAD:   begin next_j = sel_data; next_k = ~sel_data; end
            OP_SET:    next_j = sel_data;
            OP_CLR:    next_k = sel_data;
            OP_TOGGLE: begin next_j = sel_data; next_k = sel_data; end
            OP_INC:    begin next_j = inc_t;    next_k = inc_t;     end
            OP_DEC:    begin next_j = dec_t;    next_k = dec_t;     end
            default:   ;
        endcase
    end

`ifdef JK_BANK_ARB_WRAP_CHK_EN
    logic wrap_pend;
    logic wrap_now;

    assign wrap_now = (sel_op == OP_INC && (&bank_q)) || (sel_op == OP_DEC && !(|bank_q));
`else
    assign ovf = 1'b0;
`endif

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!cl) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last_gnt <= 1'b1;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            bank_j   <= '0;
            bank_k   <= '0;
            bank_cl  <= 1'b0;
            rdata    <= '0;
`ifdef JK_BANK_ARB_WRAP_CHK_EN
            ovf       <= 1'b0;
            wrap_pend <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bank_cl <= 1'b1;
                    if (req0 || req1) begin
                        state   <= DRIVE;
                        owner   <= win;
                        gnt0    <= !win;
                        gnt1    <= win;
                        bank_j  <= next_j;
                        bank_k  <= next_k;
                        bank_cl <= (sel_op != OP_CLRALL);
`ifdef JK_BANK_ARB_WRAP_CHK_EN
                        wrap_pend <= wrap_now;
`endif
                    end
                end
                DRIVE: begin
                    // Slave latches take the new value on this cycle's falling edge.
                    state   <= SETTLE;
                    bank_j  <= '0;
                    bank_k  <= '0;
                    bank_cl <= 1'b1;
                end
                SETTLE: begin
                    state <= RESP;
                    rdata <= bank_q;
                    done0 <= !owner;
                    done1 <= owner;
`ifdef JK_BANK_ARB_WRAP_CHK_EN
                    ovf <= wrap_pend;
`endif
                end
                RESP: begin
                    state    <= IDLE;
                    gnt0     <= 1'b0;
                    gnt1     <= 1'b0;
                    done0    <= 1'b0;
                    done1    <= 1'b0;
                    last_gnt <= owner;
`ifdef JK_BANK_ARB_WRAP_CHK_EN
                    ovf <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
